// File: rtl/tbus_pkg.sv
// tbus_pkg: shared types and constants for the tristate-bus receiver.
//   tbus_rx_state_t    - receiver FSM states
//   TBUS_W_DEFAULT     - default data bits per frame
//   TBUS_GUARD_DEFAULT - default turnaround guard length in cycles
//   TBUS_GCNT_W        - guard down-counter width (guard length 1..15)
package tbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP  = 2'd2,
        ST_GUARD = 2'd3
    } tbus_rx_state_t;

    localparam int TBUS_W_DEFAULT     = 8;
    localparam int TBUS_GUARD_DEFAULT = 2;
    localparam int TBUS_GCNT_W        = 4;

endpackage

// File: rtl/tbus_rx_fifo2.sv
// tbus_rx_fifo2: 2-entry valid/ready word buffer for the bus receiver.
//   clk, rstb           - clock, asynchronous active-low reset
//   push, push_data     - write request and word
//   out_data, out_valid - head word and non-empty flag
//   out_ready           - consumer takes the head when out_valid & out_ready
//   overrun             - one-cycle pulse when a push is dropped (buffer full)
// A pop and a push on the same edge are both honoured: the pop frees its
// slot first, so a full buffer still accepts the incoming word.
module tbus_rx_fifo2
    import tbus_pkg::*;
#(
    parameter int W = TBUS_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun
);

    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [1:0]   count_r;
    logic         valid_r;
    logic         overrun_r;
    logic         pop_s;

    // Pop qualifier: consumer handshake on a non-empty buffer.
    always_comb begin
        pop_s = 1'b0;
        if (valid_r && out_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Buffer storage, occupancy and overrun pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            head_r    <= {W{1'b0}};
            tail_r    <= {W{1'b0}};
            count_r   <= 2'd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            case ({push, pop_s})
                2'b10: begin
                    case (count_r)
                        2'd0: begin
                            head_r  <= push_data;
                            count_r <= 2'd1;
                            valid_r <= 1'b1;
                        end
                        2'd1: begin
                            tail_r  <= push_data;
                            count_r <= 2'd2;
                        end
                        default: begin
                            overrun_r <= 1'b1;
                        end
                    endcase
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                    valid_r <= (count_r == 2'd2);
                end
                2'b11: begin
                    // Occupancy is unchanged; the head advances.
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end else begin
                        head_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign out_data  = head_r;
    assign out_valid = valid_r;
    assign overrun   = overrun_r;

endmodule

// File: rtl/tbus_rx.sv
// tbus_rx: receiving end of the shared single-wire tristate bus.
//   clk, rstb  - clock (one bus bit per cycle), asynchronous active-low reset
//   en         - receiver enable; low aborts any frame and holds IDLE
//   rxd        - resolved bus line (idle/released reads 1)
//   out_data   - head-of-buffer word
//   out_valid  - buffer non-empty
//   out_ready  - consumer accept
//   frame_err  - one-cycle pulse when the stop bit samples 0
//   overrun    - one-cycle pulse when a good word is dropped (buffer full)
//   busy       - receiver is not idle
// Frame: start bit (0), W data bits LSB first, stop bit (1), then a guard
// window of GUARD cycles in which the line is ignored while the remote
// driver releases the bus.
module tbus_rx
    import tbus_pkg::*;
#(
    parameter int W     = TBUS_W_DEFAULT,
    parameter int GUARD = TBUS_GUARD_DEFAULT
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         en,
    input  logic         rxd,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int BCW = $clog2(W + 1);
    localparam logic [BCW-1:0]         LAST_BIT   = BCW'(W - 1);
    localparam logic [TBUS_GCNT_W-1:0] GUARD_LOAD = TBUS_GCNT_W'(GUARD - 1);

    tbus_rx_state_t         state_r;
    logic [BCW-1:0]         bit_cnt_r;
    logic [TBUS_GCNT_W-1:0] guard_cnt_r;
    logic [W-1:0]           shift_r;
    logic                   frame_err_r;
    logic                   busy_r;
    logic                   push_s;

    // A good stop bit pushes the assembled word into the buffer.
    always_comb begin
        push_s = 1'b0;
        if (en && (state_r == ST_STOP) && rxd) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Frame FSM with shift register, counters and registered status outputs.
    // busy_r is loaded from the next state so it tracks state != IDLE.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {BCW{1'b0}};
            guard_cnt_r <= {TBUS_GCNT_W{1'b0}};
            shift_r     <= {W{1'b0}};
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (!en) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!rxd) begin
                            bit_cnt_r <= {BCW{1'b0}};
                            state_r   <= ST_DATA;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        // Shift in at the MSB so the first bit ends at the LSB.
                        shift_r   <= {rxd, shift_r[W-1:1]};
                        bit_cnt_r <= bit_cnt_r + BCW'(1'b1);
                        busy_r    <= 1'b1;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_STOP: begin
                        if (!rxd) begin
                            frame_err_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b0;
                        end
                        guard_cnt_r <= GUARD_LOAD;
                        state_r     <= ST_GUARD;
                        busy_r      <= 1'b1;
                    end
                    ST_GUARD: begin
                        if (guard_cnt_r == {TBUS_GCNT_W{1'b0}}) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            guard_cnt_r <= guard_cnt_r - TBUS_GCNT_W'(1'b1);
                            busy_r      <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    tbus_rx_fifo2 #(
        .W(W)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .push     (push_s),
        .push_data(shift_r),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule
